// File: rtl/robot_sup_pkg.sv
// Shared types and encodings for the pipe-cleaning robot mission supervisor.
package robot_sup_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ARM    = 4'd1,
    SAMPLE = 4'd2,
    DECIDE = 4'd3,
    ISSUE  = 4'd4,
    EXEC   = 4'd5,
    STEP   = 4'd6,
    DONE   = 4'd7,
    FAULT  = 4'd8
  } state_e;

  // Actuator command encodings carried on cmd_op
  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_FRONT  = 2'b01;
  localparam logic [1:0] OP_TURN   = 2'b10;
  localparam logic [1:0] OP_REMOVE = 2'b11;

  // Fault reasons reported on fault_code
  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_STUCK   = 2'b01;
  localparam logic [1:0] FLT_TMO     = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  // A mission is in progress in every state except the three resting ones.
  function automatic logic is_busy(input state_e s);
    return !(s inside {IDLE, DONE, FAULT});
  endfunction

endpackage

// File: rtl/robot_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module robot_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, increment unless already all-ones, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/robot_mission_supervisor.sv
// Mission sequencer: samples sensors, steps the robot FSM, hands its decoded
// command to the actuator and watches for end-of-mission and fault conditions.
module robot_mission_supervisor
  import robot_sup_pkg::*;
#(
  parameter int TIMEOUT   = 200,
  parameter int TMO_W     = 8,
  parameter int MAX_TURNS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             front,
  input  logic             turn,
  input  logic             remove,
  output logic             sense_strobe,
  output logic             robot_rst_n,
  output logic             robot_step,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  input  logic             cmd_ready,
  input  logic             act_done,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] move_cnt,
  output logic [CNT_W-1:0] remove_cnt
);

  localparam int TURN_W = $clog2(MAX_TURNS + 1);
  // Value of the timeout counter during the last allowed cycle of a handshake.
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  // Turn run length that the next completed turn pushes to the stuck limit.
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(MAX_TURNS - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [1:0]        code_q, code_d;
  logic              robot_step_q, sense_strobe_q, cmd_valid_q, busy_q, robot_rst_n_q;

  logic [2:0]        cmd_s;
  logic              clr_all_s, clr_turn_s;
  logic              inc_move_s, inc_remove_s, inc_turn_s;
  logic [TURN_W-1:0] turn_run_s;

  assign cmd_s = {front, turn, remove};

  // Next-state, latched-command, timeout and counter-control decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tmo_d        = tmo_q;
    stop_pend_d  = stop_pend_q;
    done_d       = done_q;
    fault_d      = fault_q;
    code_d       = code_q;
    clr_all_s    = 1'b0;
    clr_turn_s   = 1'b0;
    inc_move_s   = 1'b0;
    inc_remove_s = 1'b0;
    inc_turn_s   = 1'b0;
    case (state_q)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_d     = ARM;
          done_d      = 1'b0;
          fault_d     = 1'b0;
          code_d      = FLT_NONE;
          stop_pend_d = 1'b0;
          clr_all_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ARM: begin
        state_d     = SAMPLE;
        stop_pend_d = stop_pend_q | stop;
      end
      SAMPLE: begin
        state_d     = DECIDE;
        stop_pend_d = stop_pend_q | stop;
      end
      DECIDE: begin
        if (stop || stop_pend_q) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else begin
          case (cmd_s)
            3'b000: begin
              state_d = DONE;
              done_d  = 1'b1;
            end
            3'b100: begin
              state_d = ISSUE;
              op_d    = OP_FRONT;
              tmo_d   = '0;
            end
            3'b010: begin
              state_d = ISSUE;
              op_d    = OP_TURN;
              tmo_d   = '0;
            end
            3'b001: begin
              state_d = ISSUE;
              op_d    = OP_REMOVE;
              tmo_d   = '0;
            end
            default: begin
              state_d = FAULT;
              fault_d = 1'b1;
              code_d  = FLT_ILLEGAL;
            end
          endcase
        end
      end
      ISSUE: begin
        stop_pend_d = stop_pend_q | stop;
        // Timeout is checked first so it beats a same-cycle cmd_ready.
        if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
          code_d  = FLT_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (cmd_ready) begin
            state_d = EXEC;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      EXEC: begin
        stop_pend_d = stop_pend_q | stop;
        if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
          code_d  = FLT_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (act_done) begin
            state_d = STEP;
            case (op_q)
              OP_FRONT: begin
                inc_move_s = 1'b1;
                clr_turn_s = 1'b1;
              end
              OP_REMOVE: begin
                inc_remove_s = 1'b1;
              end
              OP_TURN: begin
                inc_turn_s = 1'b1;
                if (turn_run_s == TURN_LAST) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
                  code_d  = FLT_STUCK;
                end else begin
                  state_d = STEP;
                end
              end
              default: begin
                state_d = STEP;
              end
            endcase
          end else begin
            state_d = EXEC;
          end
        end
      end
      STEP: begin
        if (stop || stop_pend_q) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else begin
          state_d = SAMPLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, mission status and output registers (outputs track the next state).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      op_q           <= OP_NONE;
      tmo_q          <= '0;
      stop_pend_q    <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
      code_q         <= FLT_NONE;
      robot_step_q   <= 1'b0;
      sense_strobe_q <= 1'b0;
      cmd_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      robot_rst_n_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      tmo_q          <= tmo_d;
      stop_pend_q    <= stop_pend_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
      code_q         <= code_d;
      robot_step_q   <= (state_d == ARM) || (state_d == STEP);
      sense_strobe_q <= (state_d == SAMPLE);
      cmd_valid_q    <= (state_d == ISSUE);
      busy_q         <= is_busy(state_d);
      robot_rst_n_q  <= is_busy(state_d);
    end
  end

  robot_sat_counter #(.W(CNT_W)) u_move_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (clr_all_s),
    .inc_i   (inc_move_s),
    .count_o (move_cnt)
  );

  robot_sat_counter #(.W(CNT_W)) u_remove_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (clr_all_s),
    .inc_i   (inc_remove_s),
    .count_o (remove_cnt)
  );

  robot_sat_counter #(.W(TURN_W)) u_turn_run (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (clr_all_s | clr_turn_s),
    .inc_i   (inc_turn_s),
    .count_o (turn_run_s)
  );

  assign robot_step   = robot_step_q;
  assign sense_strobe = sense_strobe_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = op_q;
  assign busy         = busy_q;
  assign robot_rst_n  = robot_rst_n_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;

endmodule

// File: tb/tb_robot_mission_supervisor.sv
// Self-checking bench for robot_mission_supervisor: a table of actions per
// mission plus hand-written done/timeout/illegal/stop/reset sequences.
module tb_robot_mission_supervisor;

  logic        clock = 1'b0;
  logic        reset, start, stop, front, turn, remove, cmd_ready, act_done;
  logic        sense_strobe, robot_rst_n, robot_step, cmd_valid, busy, done, fault;
  logic [1:0]  cmd_op, fault_code;
  logic [15:0] move_cnt, remove_cnt;

  int errors = 0;
  int checks = 0;
  logic [1:0] sb_q[$];

  typedef struct {
    logic [2:0] cmd;
    int         rdy_dly;
    int         done_dly;
    logic [1:0] op;
    int         mv;
    int         rm;
    logic       step;
    logic       flt;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[10];
  vec_t v;

  robot_mission_supervisor dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .front        (front),
    .turn         (turn),
    .remove       (remove),
    .sense_strobe (sense_strobe),
    .robot_rst_n  (robot_rst_n),
    .robot_step   (robot_step),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .act_done     (act_done),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code),
    .move_cnt     (move_cnt),
    .remove_cnt   (remove_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the command to be presented to the actuator.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(cmd_valid), 32'd1);
  endtask

  task automatic sb_check(input string name);
    logic [1:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got op %0h", name, cmd_op);
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'(cmd_op), 32'(e));
    end
  endtask

  // One full action, entered with the DUT in ARM or STEP.
  task automatic do_vec(input vec_t x, input int idx);
    {front, turn, remove} = x.cmd;
    sb_q.push_back(x.op);
    tick();
    chk($sformatf("v%0d_strobe", idx), 32'(sense_strobe), 32'd1);
    chk($sformatf("v%0d_no_step_sample", idx), 32'(robot_step), 32'd0);
    wait_valid($sformatf("v%0d_valid_seen", idx));
    sb_check($sformatf("v%0d_cmd_op", idx));
    repeat (x.rdy_dly) tick();
    chk($sformatf("v%0d_valid_hold", idx), 32'({cmd_valid, cmd_op}), 32'({1'b1, x.op}));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk($sformatf("v%0d_valid_drop", idx), 32'(cmd_valid), 32'd0);
    repeat (x.done_dly) tick();
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    chk($sformatf("v%0d_step", idx), 32'(robot_step), 32'(x.step));
    chk($sformatf("v%0d_fault", idx), 32'({fault, fault_code}), 32'({x.flt, x.code}));
    chk($sformatf("v%0d_move_cnt", idx), 32'(move_cnt), 32'(x.mv));
    chk($sformatf("v%0d_remove_cnt", idx), 32'(remove_cnt), 32'(x.rm));
    if (x.flt) begin
      tick();
      chk($sformatf("v%0d_no_step_after_fault", idx), 32'(robot_step), 32'd0);
      chk($sformatf("v%0d_rst_n_fault", idx), 32'({robot_rst_n, busy}), 32'd0);
    end
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_arm"}, 32'({robot_step, robot_rst_n, busy}), 32'b111);
    chk({name, "_cleared"}, 32'({done, fault, fault_code, move_cnt, remove_cnt}), 32'd0);
  endtask

  initial begin
    // cmd, rdy, dly, op, mv, rm, step, flt, code
    vecs[0] = '{cmd:3'b100, rdy_dly:0, done_dly:2, op:2'b01, mv:1, rm:0, step:1'b1, flt:1'b0, code:2'b00};
    vecs[1] = '{cmd:3'b001, rdy_dly:2, done_dly:0, op:2'b11, mv:1, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[2] = '{cmd:3'b010, rdy_dly:0, done_dly:1, op:2'b10, mv:1, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[3] = '{cmd:3'b010, rdy_dly:1, done_dly:0, op:2'b10, mv:1, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[4] = '{cmd:3'b010, rdy_dly:0, done_dly:3, op:2'b10, mv:1, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[5] = '{cmd:3'b100, rdy_dly:3, done_dly:1, op:2'b01, mv:2, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[6] = '{cmd:3'b010, rdy_dly:0, done_dly:0, op:2'b10, mv:2, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[7] = '{cmd:3'b010, rdy_dly:1, done_dly:1, op:2'b10, mv:2, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[8] = '{cmd:3'b010, rdy_dly:0, done_dly:2, op:2'b10, mv:2, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    vecs[9] = '{cmd:3'b010, rdy_dly:2, done_dly:0, op:2'b10, mv:2, rm:1, step:1'b0, flt:1'b1, code:2'b01};

    reset = 1'b0; start = 1'b0; stop = 1'b0;
    front = 1'b0; turn = 1'b0; remove = 1'b0;
    cmd_ready = 1'b0; act_done = 1'b0;
    repeat (2) tick();
    chk("reset_outputs", 32'({sense_strobe, robot_rst_n, robot_step, cmd_valid, cmd_op,
                              busy, done, fault, fault_code}), 32'd0);
    chk("reset_counts", 32'({move_cnt, remove_cnt}), 32'd0);
    reset = 1'b1;
    tick();

    // Mission 1: table of actions ending in stuck-turning fault.
    do_start("m1");
    for (int i = 0; i < 10; i++) begin
      do_vec(vecs[i], i);
    end

    // Mission 2: two actions then stand-by.
    do_start("m2");
    v = '{cmd:3'b100, rdy_dly:0, done_dly:2, op:2'b01, mv:1, rm:0, step:1'b1, flt:1'b0, code:2'b00};
    do_vec(v, 20);
    v = '{cmd:3'b001, rdy_dly:1, done_dly:0, op:2'b11, mv:1, rm:1, step:1'b1, flt:1'b0, code:2'b00};
    do_vec(v, 21);
    {front, turn, remove} = 3'b000;
    repeat (3) tick();
    chk("done_state", 32'({done, busy, robot_rst_n, fault}), 32'b1000);
    repeat (4) tick();
    chk("done_counts_hold", 32'({move_cnt, remove_cnt}), 32'h0001_0001);

    // Mission 3: actuator never ready -> timeout, even with late cmd_ready.
    do_start("m3");
    {front, turn, remove} = 3'b100;
    sb_q.push_back(2'b01);
    tick();
    wait_valid("tmo_valid_seen");
    sb_check("tmo_cmd_op");
    repeat (199) tick();
    chk("tmo_not_early", 32'({cmd_valid, fault}), 32'b10);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("tmo_fault", 32'({fault, fault_code, cmd_valid, busy}), 32'b11000);

    // Mission 4: two command bits at once -> illegal command fault.
    do_start("m4");
    {front, turn, remove} = 3'b110;
    tick();
    chk("ill_no_valid_sample", 32'(cmd_valid), 32'd0);
    tick();
    chk("ill_no_valid_decide", 32'(cmd_valid), 32'd0);
    tick();
    chk("ill_fault", 32'({fault, fault_code, cmd_valid}), 32'b1110);

    // Mission 5: stop during EXEC finishes the action, one step, then IDLE.
    do_start("m5");
    {front, turn, remove} = 3'b001;
    sb_q.push_back(2'b11);
    tick();
    wait_valid("stop_valid_seen");
    sb_check("stop_cmd_op");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    chk("stop_step", 32'({robot_step, busy, remove_cnt}), 32'({2'b11, 16'd1}));
    tick();
    chk("stop_idle", 32'({robot_step, busy, robot_rst_n, sense_strobe, done, fault}), 32'd0);
    repeat (3) tick();
    chk("stop_no_more_step", 32'({robot_step, remove_cnt}), 32'({1'b0, 16'd1}));

    // Mission 6: asynchronous reset in the middle of ISSUE.
    do_start("m6");
    {front, turn, remove} = 3'b100;
    sb_q.push_back(2'b01);
    tick();
    wait_valid("rst_valid_seen");
    sb_check("rst_cmd_op");
    #2 reset = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({cmd_valid, robot_rst_n, busy, robot_step, cmd_op, sense_strobe}), 32'd0);
    #3 reset = 1'b1;
    tick();
    chk("rst_stays_idle", 32'({busy, robot_rst_n}), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robot_mission_supervisor.md
Name: robot_mission_supervisor

Overview:
- Sequences one mission of the pipe-cleaning robot FSM.
- Captures a sensor snapshot, decodes the FSM's front/turn/remove command, and hands it to the actuator over a valid/ready + done handshake.
- Advances the FSM one step per completed action, and detects mission end (stand-by), stuck rotation, actuator timeout and illegal commands.
- Sits between the robot FSM, the sensor front-end and the actuator driver.

Parameters:
- TIMEOUT, 200: max cycles from cmd_valid rise to act_done before fault.
- TMO_W, 8: width of the timeout counter; TIMEOUT must fit.
- MAX_TURNS, 4: consecutive turn commands without a front command before fault.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level/pulse; begins a mission from IDLE, DONE or FAULT
- stop  in  1  requests an orderly return to IDLE
- front  in  1  robot FSM command
- turn  in  1  robot FSM command
- remove  in  1  robot FSM command
- sense_strobe  out  1  one-cycle pulse; sensor front-end latches new head/left/under/barrier, stable from the next cycle
- robot_rst_n  out  1  drives the robot FSM reset
- robot_step  out  1  registered one-cycle pulse; drives the robot FSM clock pin, so the FSM advances on its rise
- cmd_valid  out  1  actuator command valid
- cmd_op  out  2  01=front, 10=turn, 11=remove
- cmd_ready  in  1  actuator accepts the command
- act_done  in  1  one-cycle pulse; actuator finished the action
- busy  out  1  high in any state except IDLE/DONE/FAULT
- done  out  1  sticky; mission ended in stand-by
- fault  out  1  sticky
- fault_code  out  2  01=stuck turning, 10=timeout, 11=illegal command
- move_cnt  out  CNT_W  completed front actions, saturating
- remove_cnt  out  CNT_W  completed remove actions, saturating

Behaviour:
- Reset (async, active-low): state=IDLE. All outputs 0 except robot_rst_n=0. Counters 0, fault_code=00.
- All outputs are registered or decoded from the state register; no input-to-output combinational paths.
- robot_rst_n=0 in IDLE, DONE and FAULT; 1 in every other state.
- IDLE/DONE/FAULT + start=1 -> ARM. On that transition: clear done, fault, fault_code, move_cnt, remove_cnt, turn_run.
- ARM (1 cycle): robot_step=1, moving the FSM from its reset state to first-move -> SAMPLE.
- SAMPLE (1 cycle): sense_strobe=1 -> DECIDE.
- DECIDE (1 cycle), with stop=1 having priority -> IDLE:
  - {front,turn,remove}=000 -> DONE, done=1.
  - Exactly one bit set -> ISSUE. Latch cmd_op; clear the timeout counter.
  - More than one bit set -> FAULT, code 11.
- ISSUE: cmd_valid=1 with cmd_op held stable until a cycle with cmd_ready=1 -> EXEC. Timeout counter increments every cycle.
- EXEC: wait for act_done -> STEP. On act_done:
  - front: move_cnt+1 and turn_run=0.
  - remove: remove_cnt+1.
  - turn: turn_run+1. If turn_run reaches MAX_TURNS -> FAULT, code 01, instead of STEP.
- Timeout: counter reaches TIMEOUT in ISSUE or EXEC -> FAULT, code 10. Timeout beats a simultaneous cmd_ready or act_done.
- STEP (1 cycle): robot_step=1 -> SAMPLE. stop=1 here -> IDLE after the pulse.
- stop in ISSUE/EXEC is remembered and takes effect at the next STEP. The in-flight handshake is never abandoned except by timeout.
- act_done outside EXEC: ignored. cmd_ready outside ISSUE: ignored.
- Counters saturate at all-ones.
- Minimum per-action latency: DECIDE, ISSUE (1 cycle if ready already high), EXEC, STEP, SAMPLE = 5 cycles.
- A reset assertion mid-operation drops cmd_valid immediately and forces robot_rst_n=0.

Decomposition:
- Package robot_sup_pkg: state enum (IDLE, ARM, SAMPLE, DECIDE, ISSUE, EXEC, STEP, DONE, FAULT), OP_FRONT/OP_TURN/OP_REMOVE, FLT_STUCK/FLT_TMO/FLT_ILLEGAL.
- One sub-module: robot_sat_counter (parameterised width, clear, increment, saturate), instanced for move_cnt, remove_cnt and turn_run.

Test Plan:
- Reset then start. Robot yields front, cmd_ready=1, act_done 2 cycles later -> cmd_op=01; move_cnt=1; robot_step pulses once in ARM and once in STEP; sense_strobe follows 1 cycle after STEP.
- Robot yields 000 in DECIDE after two actions -> done=1, busy=0, robot_rst_n=0, counts hold until next start.
- Four consecutive turn actions with no front -> fault=1, fault_code=01 after the 4th act_done; no robot_step after it.
- cmd_ready held 0 for TIMEOUT cycles -> fault_code=10, cmd_valid drops; the same cycle as cmd_ready=1 still faults.
- Force front=turn=1 in DECIDE -> fault_code=11, cmd_valid never asserts. Then start -> fault clears, ARM re-entered.
- stop asserted during EXEC -> act_done completes, remove_cnt increments, one STEP pulse, then IDLE; reset asserted mid-ISSUE -> all outputs at reset values asynchronously.
